// File: rtl/srio_patgen_pkg.sv
// Shared types and helpers for the SRIO NWRITE pattern generator.
// State encoding, PRBS lane constants and the last-beat byte-enable mask.
package srio_patgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARM       = 2'd1,
    ST_SEND      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam int MAX_LEN_DEF = 256;
  localparam int BYTES_DEF   = 8;
  localparam int MAX_BYTES   = 16;

  localparam int LANE_W      = 64;
  localparam int LFSR_W      = 31;
  localparam int LFSR_TAP_HI = 30;
  localparam int LFSR_TAP_LO = 27;

  // Bit nbytes-1 carries byte 0; r = len mod nbytes, r==0 means a full last beat.
  function automatic logic [MAX_BYTES-1:0] keep_mask(input logic [4:0] r,
                                                     input logic [4:0] nbytes);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if ((5'(i) < nbytes) && ((r == 5'd0) || ((nbytes - 5'd1 - 5'(i)) < r)))
        m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/srio_patgen_lfsr.sv
// One 64-bit PRBS lane: Fibonacci LFSR x^31+x^28+1, 64 steps per beat.
// Only instantiated when SRIO_PATGEN_LFSR_EN is defined.
module srio_patgen_lfsr
  import srio_patgen_pkg::*;
(
  input  logic              log_clk,
  input  logic              log_rst,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [LANE_W-1:0] seed_i,
  output logic [LANE_W-1:0] word_o
);

  logic [LFSR_W-1:0] state_q, state_d, seed_fold, seed_st;
  logic [LANE_W-1:0] word_q, word_d;

  function automatic logic [LFSR_W+LANE_W-1:0] run(input logic [LFSR_W-1:0] s_in);
    logic [LFSR_W-1:0] s;
    logic [LANE_W-1:0] w;
    logic              fb;
    s = s_in;
    w = '0;
    for (int i = LANE_W - 1; i >= 0; i--) begin
      w[i] = s[LFSR_W-1];
      fb   = s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO];
      s    = {s[LFSR_W-2:0], fb};
    end
    return {s, w};
  endfunction

  // Fold the whole seed word into the register; an all-zero state would lock up.
  assign seed_fold = seed_i[30:0] ^ seed_i[61:31] ^ {29'd0, seed_i[63:62]};
  assign seed_st   = (seed_fold == '0) ? LFSR_W'(1) : seed_fold;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    if (load_i)    {state_d, word_d} = run(seed_st);
    else if (en_i) {state_d, word_d} = run(state_q);
  end

  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      state_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/srio_nwr_pattern_gen.sv
// Programmable NWRITE burst generator on the SRIO initiator user stream.
// Optional PRBS data under macro SRIO_PATGEN_LFSR_EN (adds cfg_mode_in).
module srio_nwr_pattern_gen
  import srio_patgen_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 34,
  parameter int LEN_W   = 20,
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 16
) (
  input  logic                log_clk,
  input  logic                log_rst,
  input  logic                cfg_start_in,
  input  logic                cfg_abort_in,
  input  logic [LEN_W-1:0]    cfg_len_in,
  input  logic [ADDR_W-1:0]   cfg_addr_in,
  input  logic [CNT_W-1:0]    cfg_count_in,
  input  logic [DATA_W-1:0]   cfg_seed_in,
`ifdef SRIO_PATGEN_LFSR_EN
  input  logic                cfg_mode_in,
`endif
  input  logic                nwr_ready_in,
  input  logic                nwr_busy_in,
  input  logic                nwr_done_in,
  input  logic                user_tready_in,
  output logic [ADDR_W-1:0]   user_addr_o,
  output logic [LEN_W-1:0]    user_tsize_o,
  output logic [DATA_W-1:0]   user_tdata_o,
  output logic [DATA_W/8-1:0] user_tkeep_o,
  output logic                user_tvalid_o,
  output logic                user_tfirst_o,
  output logic                user_tlast_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [CNT_W-1:0]    xfer_cnt_o
);

  localparam int         BYTES = DATA_W / 8;
  localparam int         BLOG  = $clog2(BYTES);
  localparam logic [4:0] NB    = 5'(BYTES);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q, tsize_q, beats_q, beat_q;
  logic [CNT_W-1:0]    count_q, xfer_q;
  logic [DATA_W-1:0]   cnt_data_q;
  logic [BYTES-1:0]    keep_q, last_keep;
  logic                valid_q, first_q, last_q, busy_q, done_q, err_q, abort_q;
  logic                cfg_legal, start_ok, beat_acc, next_is_last;
  logic [4:0]          rem;

  assign cfg_legal = (cfg_len_in != '0) && (cfg_len_in <= LEN_W'(MAX_LEN)) &&
                     (cfg_count_in != '0);
  assign start_ok  = cfg_start_in && (state_q == ST_IDLE) && cfg_legal;
  assign beat_acc  = (state_q == ST_SEND) && valid_q && user_tready_in;

  assign rem          = 5'(len_q[BLOG-1:0]);
  assign last_keep    = BYTES'(keep_mask(rem, NB));
  assign next_is_last = ((beat_q + LEN_W'(1)) == (beats_q - LEN_W'(1)));

  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      tsize_q    <= '0;
      beats_q    <= '0;
      beat_q     <= '0;
      count_q    <= '0;
      xfer_q     <= '0;
      cnt_data_q <= '0;
      keep_q     <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (cfg_abort_in && (state_q != ST_IDLE)) abort_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            len_q      <= cfg_len_in;
            tsize_q    <= cfg_len_in - LEN_W'(1);
            beats_q    <= (cfg_len_in + LEN_W'(BYTES - 1)) >> BLOG;
            addr_q     <= cfg_addr_in;
            count_q    <= cfg_count_in;
            cnt_data_q <= cfg_seed_in;
            xfer_q     <= '0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_ARM;
          end else if (cfg_start_in) begin
            err_q <= 1'b1;
          end
        end

        ST_ARM: begin
          if (nwr_ready_in && !nwr_busy_in) begin
            beat_q  <= '0;
            state_q <= ST_SEND;
          end
        end

        // First SEND cycle presents beat 0; afterwards each accept loads the next beat.
        ST_SEND: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
            first_q <= 1'b1;
            last_q  <= (beats_q == LEN_W'(1));
            keep_q  <= (beats_q == LEN_W'(1)) ? last_keep : '1;
          end else if (beat_acc) begin
            cnt_data_q <= cnt_data_q + DATA_W'(1);
            if (last_q) begin
              valid_q <= 1'b0;
              first_q <= 1'b0;
              last_q  <= 1'b0;
              keep_q  <= '0;
              state_q <= ST_WAIT_DONE;
            end else begin
              beat_q  <= beat_q + LEN_W'(1);
              first_q <= 1'b0;
              last_q  <= next_is_last;
              keep_q  <= next_is_last ? last_keep : '1;
            end
          end
        end

        ST_WAIT_DONE: begin
          if (nwr_done_in) begin
            xfer_q <= xfer_q + CNT_W'(1);
            if (((xfer_q + CNT_W'(1)) == count_q) || abort_q || cfg_abort_in) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              abort_q <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              addr_q  <= addr_q + ADDR_W'(len_q);
              state_q <= ST_ARM;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SRIO_PATGEN_LFSR_EN
  logic              mode_q;
  logic [DATA_W-1:0] prbs_data;

  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst)       mode_q <= 1'b0;
    else if (start_ok) mode_q <= cfg_mode_in;
  end

  for (genvar g = 0; g < DATA_W / LANE_W; g++) begin : g_lane
    srio_patgen_lfsr u_lfsr (
      .log_clk (log_clk),
      .log_rst (log_rst),
      .load_i  (start_ok),
      .en_i    (beat_acc),
      .seed_i  (cfg_seed_in[g*LANE_W +: LANE_W]),
      .word_o  (prbs_data[g*LANE_W +: LANE_W])
    );
  end

  assign user_tdata_o = mode_q ? prbs_data : cnt_data_q;
`else
  assign user_tdata_o = cnt_data_q;
`endif

  assign user_addr_o   = addr_q;
  assign user_tsize_o  = tsize_q;
  assign user_tkeep_o  = keep_q;
  assign user_tvalid_o = valid_q;
  assign user_tfirst_o = first_q;
  assign user_tlast_o  = last_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign xfer_cnt_o    = xfer_q;

endmodule

// File: tb/tb_srio_nwr_pattern_gen.sv
// Scoreboard bench for srio_nwr_pattern_gen (default build, counter data).
module tb_srio_nwr_pattern_gen;

  logic        log_clk = 1'b0;
  logic        log_rst = 1'b1;
  logic        cfg_start_in = 1'b0, cfg_abort_in = 1'b0;
  logic [19:0] cfg_len_in = '0;
  logic [33:0] cfg_addr_in = '0;
  logic [15:0] cfg_count_in = '0;
  logic [63:0] cfg_seed_in = '0;
  logic        nwr_ready_in = 1'b1, nwr_busy_in = 1'b0, nwr_done_in = 1'b0;
  logic        user_tready_in = 1'b0;
  logic [33:0] user_addr_o;
  logic [19:0] user_tsize_o;
  logic [63:0] user_tdata_o;
  logic [7:0]  user_tkeep_o;
  logic        user_tvalid_o, user_tfirst_o, user_tlast_o, busy_o, done_o, err_o;
  logic [15:0] xfer_cnt_o;

  srio_nwr_pattern_gen dut (
    .log_clk(log_clk), .log_rst(log_rst),
    .cfg_start_in(cfg_start_in), .cfg_abort_in(cfg_abort_in),
    .cfg_len_in(cfg_len_in), .cfg_addr_in(cfg_addr_in),
    .cfg_count_in(cfg_count_in), .cfg_seed_in(cfg_seed_in),
    .nwr_ready_in(nwr_ready_in), .nwr_busy_in(nwr_busy_in), .nwr_done_in(nwr_done_in),
    .user_tready_in(user_tready_in),
    .user_addr_o(user_addr_o), .user_tsize_o(user_tsize_o), .user_tdata_o(user_tdata_o),
    .user_tkeep_o(user_tkeep_o), .user_tvalid_o(user_tvalid_o),
    .user_tfirst_o(user_tfirst_o), .user_tlast_o(user_tlast_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .xfer_cnt_o(xfer_cnt_o)
  );

  initial forever #5 log_clk = ~log_clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        first;
    logic        last;
    logic [33:0] addr;
    logic [19:0] tsize;
  } beat_t;

  beat_t sb[$];

  logic [147:0] outs;
  assign outs = {user_addr_o, user_tsize_o, user_tdata_o, user_tkeep_o, user_tvalid_o,
                 user_tfirst_o, user_tlast_o, busy_o, done_o, err_o, xfer_cnt_o};

  int checks = 0, errors = 0;
  int err_seen = 0, done_seen = 0, busy_seen = 0, valid_seen = 0;
  int pkt_done = 0, pkt_beat = 0, done_cd = 0;
  bit post_busy = 0, hold = 0, rand_ready = 0, spur_req = 0;
  logic [74:0] snap;

  function automatic logic [7:0] ref_keep(input int len);
    int r;
    logic [7:0] ones;
    r = len % 8;
    ones = 8'hFF;
    return (r == 0) ? ones : ~(ones >> r);
  endfunction

  task automatic push_burst(input int len, input logic [33:0] addr, input int count,
                            input logic [63:0] seed);
    beat_t e;
    int beats, idx;
    beats = (len + 7) / 8;
    idx = 0;
    for (int p = 0; p < count; p++) begin
      for (int b = 0; b < beats; b++) begin
        e.data  = seed + 64'(idx);
        e.keep  = (b == beats - 1) ? ref_keep(len) : 8'hFF;
        e.first = (b == 0);
        e.last  = (b == beats - 1);
        e.addr  = addr + 34'(p * len);
        e.tsize = 20'(len - 1);
        sb.push_back(e);
        idx++;
      end
    end
  endtask

  // One clock of monitor, formatter model and ready generation, run at the falling edge.
  task automatic step();
    beat_t e;
    @(negedge log_clk);
    nwr_done_in = 1'b0;
    if (log_rst) begin
      hold = 0; done_cd = 0; post_busy = 0;
      nwr_busy_in = 1'b0; user_tready_in = 1'b0;
    end else begin
      if (err_o) err_seen++;
      if (done_o) done_seen++;
      if (busy_o) busy_seen++;
      if (user_tvalid_o) valid_seen++;
      if (hold) begin
        checks++;
        if ({user_tvalid_o, user_tdata_o, user_tkeep_o, user_tfirst_o, user_tlast_o} !== snap) begin
          errors++;
          $display("FAIL stall_stable: got %h required %h", {user_tvalid_o, user_tdata_o,
                   user_tkeep_o, user_tfirst_o, user_tlast_o}, snap);
        end
      end
      nwr_busy_in = post_busy;
      post_busy = 0;
      if (done_cd > 0) begin
        done_cd--;
        nwr_busy_in = 1'b1;
        if (done_cd == 0) begin nwr_done_in = 1'b1; post_busy = 1; end
      end else if (spur_req) begin
        nwr_done_in = 1'b1;
        spur_req = 0;
      end
      user_tready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      hold = 0;
      if (user_tvalid_o && user_tready_in) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data %h required no beat", user_tdata_o);
        end else begin
          e = sb.pop_front();
          if (user_tdata_o !== e.data) begin
            errors++;
            $display("FAIL beat_data: got %h required %h", user_tdata_o, e.data);
          end
          checks++;
          if ({user_tkeep_o, user_tfirst_o, user_tlast_o, user_addr_o, user_tsize_o} !==
              {e.keep, e.first, e.last, e.addr, e.tsize}) begin
            errors++;
            $display("FAIL beat_meta: got keep %h f%b l%b addr %h tsize %0d required keep %h f%b l%b addr %h tsize %0d",
                     user_tkeep_o, user_tfirst_o, user_tlast_o, user_addr_o, user_tsize_o,
                     e.keep, e.first, e.last, e.addr, e.tsize);
          end
        end
        if (user_tlast_o) begin done_cd = 3; pkt_done++; pkt_beat = 0; end
        else pkt_beat++;
      end else if (user_tvalid_o) begin
        hold = 1;
        snap = {user_tvalid_o, user_tdata_o, user_tkeep_o, user_tfirst_o, user_tlast_o};
      end
    end
  endtask

  task automatic start(input int len, input logic [33:0] addr, input int count,
                       input logic [63:0] seed);
    cfg_len_in = 20'(len); cfg_addr_in = addr; cfg_count_in = 16'(count); cfg_seed_in = seed;
    cfg_start_in = 1'b1;
    step();
    cfg_start_in = 1'b0;
  endtask

  task automatic do_burst(input string name, input int len, input logic [33:0] addr,
                          input int count, input logic [63:0] seed,
                          input bit restart, input bit spur);
    int d0, e0;
    bit got;
    d0 = done_seen; e0 = err_seen; got = 0;
    push_burst(len, addr, count, seed);
    start(len, addr, count, seed);
    for (int i = 0; i < 4000 && !got; i++) begin
      if (restart && i == 8) begin
        cfg_len_in = '0; cfg_count_in = '0; cfg_addr_in = 34'h3_0000_0000; cfg_start_in = 1'b1;
      end else cfg_start_in = 1'b0;
      if (spur && i == 12) spur_req = 1;
      step();
      if (done_seen != d0) got = 1;
    end
    cfg_start_in = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL %s_done: got no done_o required one within 4000 cycles", name); end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (done_seen - d0 != 1) begin errors++; $display("FAIL %s_done_cnt: got %0d required 1", name, done_seen - d0); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL %s_beats_left: got %0d required 0", name, sb.size()); end
    checks++;
    if (xfer_cnt_o !== 16'(count)) begin errors++; $display("FAIL %s_xfer_cnt: got %0d required %0d", name, xfer_cnt_o, count); end
    checks++;
    if (busy_o !== 1'b0 || err_seen != e0) begin
      errors++; $display("FAIL %s_idle: got busy %b err %0d required busy 0 err 0", name, busy_o, err_seen - e0);
    end
    sb.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h required 0", outs); end
    log_rst = 1'b0;
    step();
  endtask

  task automatic test_illegal(input string name, input int len, input int count);
    int e0, b0, v0;
    e0 = err_seen; b0 = busy_seen; v0 = valid_seen;
    start(len, 34'h40, count, 64'h1);
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (err_seen - e0 != 1) begin errors++; $display("FAIL %s_err: got %0d pulses required 1", name, err_seen - e0); end
    checks++;
    if (busy_seen != b0 || valid_seen != v0) begin
      errors++; $display("FAIL %s_quiet: got busy %0d valid %0d cycles required 0 0", name, busy_seen - b0, valid_seen - v0);
    end
  endtask

  task automatic test_abort();
    int d0, p0;
    bit got, fired;
    d0 = done_seen; p0 = pkt_done; got = 0; fired = 0;
    push_burst(37, 34'h2000, 4, 64'h7000);
    start(37, 34'h2000, 4, 64'h7000);
    for (int i = 0; i < 2000 && !got; i++) begin
      cfg_abort_in = 1'b0;
      if (!fired && pkt_done - p0 == 1 && pkt_beat >= 3) begin cfg_abort_in = 1'b1; fired = 1; end
      step();
      if (done_seen != d0) got = 1;
    end
    cfg_abort_in = 1'b0;
    checks++;
    if (!got || !fired) begin errors++; $display("FAIL abort_done: got done %b abort %b required 1 1", got, fired); end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (xfer_cnt_o !== 16'd2) begin errors++; $display("FAIL abort_xfer_cnt: got %0d required 2", xfer_cnt_o); end
    checks++;
    if (sb.size() != 10) begin errors++; $display("FAIL abort_beats_left: got %0d required 10", sb.size()); end
    checks++;
    if (done_seen - d0 != 1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got done %0d busy %b required 1 0", done_seen - d0, busy_o);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    int p0;
    p0 = pkt_beat;
    push_burst(64, 34'h800, 2, 64'h55);
    start(64, 34'h800, 2, 64'h55);
    for (int i = 0; i < 200 && pkt_beat < 3; i++) step();
    #1 log_rst = 1'b1;
    #1;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_async: got %h required 0", outs); end
    for (int i = 0; i < 3; i++) step();
    log_rst = 1'b0;
    sb.delete();
    pkt_beat = 0;
    step();
    checks++;
    if (xfer_cnt_o !== 16'd0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_recover: got xfer %0d busy %b required 0 0", xfer_cnt_o, busy_o);
    end
    do_burst("after_reset", 16, 34'h900, 1, 64'hABC, 0, 0);
  endtask

  initial begin
    test_reset();
    do_burst("short", 7, 34'h10, 1, 64'h1111_0000_0000_0000, 0, 0);
    do_burst("len37", 37, 34'h100, 3, 64'hFFFF_FFFF_FFFF_FFFA, 1, 0);
    rand_ready = 1;
    do_burst("stall", 256, 34'h3_FFFF_FF80, 2, 64'h0123_4567_89AB_CDEF, 0, 1);
    rand_ready = 0;
    do_burst("full_words", 24, 34'h200, 2, 64'h42, 0, 0);
    test_illegal("count0", 8, 0);
    test_illegal("len0", 0, 1);
    test_illegal("len257", 257, 1);
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
